// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, hides the 1-cycle memory latency, skid-buffers stalls.
// HALT-opcode stop is built only when FETCH_HALT_DETECT_EN is defined.
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  output logic [4:0]  prog_addr,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        redirect,
  input  logic [4:0]  redirect_addr,
  output logic [31:0] instr_out,
  output logic [4:0]  instr_pc,
  output logic        instr_valid,
  output logic        halted
);
  localparam logic [4:0] RESET_PC = 5'd0;

  logic [4:0]  pc_q;
  logic        f2_valid;
  logic [4:0]  f2_pc;
  logic        skid_valid;
  logic [31:0] skid_data;
  logic [4:0]  skid_pc;

  logic        running;
  logic        issue;
  logic        src_valid;
  logic [31:0] src_data;
  logic [4:0]  src_pc;
  logic        halt_hit;

`ifdef FETCH_HALT_DETECT_EN
  localparam logic [6:0] HALT_OPCODE = 7'b1010101;
  typedef enum logic {RUN, HALTED} state_t;
  state_t state;
  logic   halted_q;

  assign running  = (state == RUN);
  assign halt_hit = src_valid && (src_data[6:0] == HALT_OPCODE);
  assign halted   = halted_q;
`else
  assign running  = 1'b1;
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  assign prog_addr = pc_q;
  assign issue     = running && !stall && !redirect;

  // The skid entry is always older than the word in f2.
  assign src_valid = skid_valid || f2_valid;
  assign src_data  = skid_valid ? skid_data : instruction;
  assign src_pc    = skid_valid ? skid_pc : f2_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      f2_valid    <= 1'b0;
      f2_pc       <= RESET_PC;
      skid_valid  <= 1'b0;
      skid_data   <= 32'd0;
      skid_pc     <= 5'd0;
      instr_out   <= 32'd0;
      instr_pc    <= 5'd0;
      instr_valid <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
      state       <= RUN;
      halted_q    <= 1'b0;
`endif
    end else if (redirect) begin
      pc_q        <= redirect_addr;
      f2_valid    <= 1'b0;
      skid_valid  <= 1'b0;
      instr_valid <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
      state       <= RUN;
      halted_q    <= 1'b0;
`endif
    end else begin
`ifdef FETCH_HALT_DETECT_EN
      halted_q <= (state == HALTED);
`endif
      f2_valid <= issue;
      if (issue) begin
        pc_q  <= pc_q + 5'd1;
        f2_pc <= pc_q;
      end
      if (stall) begin
        if (f2_valid) begin
          skid_valid <= 1'b1;
          skid_data  <= instruction;
          skid_pc    <= f2_pc;
        end
      end else begin
        skid_valid  <= 1'b0;
        instr_valid <= src_valid;
        if (src_valid) begin
          instr_out <= src_data;
          instr_pc  <= src_pc;
        end
        // Younger speculative fetch is dropped; restart point is after HALT.
        if (halt_hit) begin
          f2_valid <= 1'b0;
          pc_q     <= src_pc + 5'd1;
`ifdef FETCH_HALT_DETECT_EN
          state    <= HALTED;
`endif
        end
      end
    end
  end

endmodule
